uart_frame_sched: RTL and testbench
===================================

Name: uart_frame_sched

Overview:
Shares the single UART transmitter between the I and U sinc3 filter channels. On every FRAME_DIV-th word_clk strobe it snapshots both filtered words and emits a fixed byte frame through a valid/ready handshake into uart_tx. The frame is SYNC, I_hi, I_lo, U_hi, U_lo, with an optional checksum byte. It sits between the two filter_sinc3 instances and uart_tx in top, in the clk (75 MHz) domain.

Parameters:
WIDTH, 16, filtered sample width. Legal range 9..16. Values narrower than 16 are zero-extended to 16 bits before splitting into bytes.
FRAME_DIV, 64, word_clk strobes per transmitted frame. Legal range 1..65535. The default keeps the 115200-baud link below saturation at a 73.2 kHz word rate.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock, 75 MHz
rst  input  1  asynchronous reset, active-high
word_clk  input  1  filter word strobe, a level signal derived from mclkin; synchronised and rising-edge detected inside the block
data_i  input  WIDTH  filtered current-channel word
data_u  input  WIDTH  filtered voltage-channel word
tx_valid  output  1  byte valid to uart_tx
tx_data  output  8  byte to uart_tx
tx_ready  input  1  uart_tx accepts the byte when tx_valid and tx_ready are both high on the same clk edge
busy  output  1  high while a frame is in flight
overrun  output  1  sticky flag, set when a frame trigger arrives while busy; cleared only by rst
overrun_cnt  output  8  saturating count of dropped frame triggers

Behaviour:
- Reset (async, rst=1):
  - tx_valid=0, tx_data=8'h00, busy=0, overrun=0, overrun_cnt=0.
  - State=IDLE; decimation counter=0; synchroniser flops=0.
- Strobe detection:
  - word_clk passes through 2 flops (s1, s2) plus a delay flop s3.
  - strb = s2 & ~s3, a one-cycle pulse per word_clk rising edge.
- Decimation:
  - div_cnt increments on each strb.
  - When strb occurs with div_cnt==FRAME_DIV-1, div_cnt wraps to 0 and a one-cycle trig is raised in the same cycle.
  - FRAME_DIV=1 produces trig on every strb.
- States:
  - IDLE: on trig, capture data_i and data_u into snapshot registers on that edge. Go to SEND with byte index 0.
  - SEND: tx_valid=1 and tx_data=frame[idx]. On tx_valid&tx_ready, idx increments. If idx was the last byte, go to IDLE and drop tx_valid on the same edge. Otherwise present the next byte on the following cycle; tx_valid stays high and there are no bubbles.
- Latency: tx_valid rises on the clk edge after the one that raised trig.
- Frame order:
  - idx0 SYNC_BYTE, idx1 I[15:8], idx2 I[7:0], idx3 U[15:8], idx4 U[7:0].
  - Frame length is 5 bytes without the optional feature.
- Handshake:
  - tx_data is stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops without acceptance, except on rst.
- busy = (state != IDLE).
- Snapshot registers are loaded only in IDLE on trig. Input changes during SEND do not affect the frame in flight.
- Overrun:
  - trig while state==SEND drops that frame; the current frame is unaffected.
  - Sets overrun=1 and increments overrun_cnt, saturating at 8'hFF.
- Simultaneous events: trig on the same edge as acceptance of the last byte counts as overrun. The block is IDLE-only for loads, with no look-ahead.
- Mid-operation rst: the frame aborts immediately and tx_valid drops asynchronously. After release the block waits for a fresh trig; the decimation count restarts at 0.

Optional Feature:
FRAME_CHECKSUM_EN:
- Defined: a 6th byte is appended at idx5, equal to I_hi ^ I_lo ^ U_hi ^ U_lo computed from the snapshot. It is sent with the same handshake, and the frame length is 6.
- Undefined: the frame is 5 bytes, and no checksum logic or register exists.

Test Plan:
1. FRAME_DIV=4, tx_ready tied 1, data_i=16'h1234, data_u=16'hABCD, 8 word_clk pulses -> exactly 2 frames A5 12 34 AB CD. tx_valid rises 1 clk after trig; overrun stays 0.
2. tx_ready backpressure (high 1 cycle in 5) -> tx_data holds each byte stable until accepted, and the byte order is unchanged.
3. data_i changes to 16'hFFFF mid-frame -> the current frame still carries 12 34; the next frame carries FF FF.
4. FRAME_DIV=1, tx_ready=0 for 300 word_clk pulses -> overrun=1, overrun_cnt=8'hFF (saturated), and the first frame's SYNC is still pending.
5. rst asserted while tx_data=I_lo -> tx_valid=0 and busy=0 immediately. After release the next frame starts from A5 only after FRAME_DIV new strobes.
6. With FRAME_CHECKSUM_EN, data 1234/ABCD -> 6th byte 12^34^AB^CD = 8'h40.

Source files
------------

// File: rtl/uart_frame_sched_if.sv
// Byte-stream handshake between the frame scheduler and the UART transmitter.
// The master presents tx_data/tx_valid and the slave accepts with tx_ready.
interface uart_frame_sched_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_frame_sched.sv
// Decimates the filter word strobe and streams SYNC, I_hi, I_lo, U_hi, U_lo
// frames into the UART. Define FRAME_CHECKSUM_EN to append an XOR checksum byte.
module uart_frame_sched #(
  parameter int         WIDTH     = 16,
  parameter int         FRAME_DIV = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 word_clk,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [WIDTH-1:0]     data_u,
  uart_frame_sched_if.master   tx,
  output logic                 busy,
  output logic                 overrun,
  output logic [7:0]           overrun_cnt
);

`ifdef FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif
  localparam logic [2:0]  LAST_IDX = 3'(FRAME_LEN - 1);
  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic        s1_reg, s2_reg, s3_reg;
  logic [15:0] div_cnt_reg, div_cnt_next;
  logic [15:0] snap_i_reg, snap_u_reg;
  logic        overrun_reg;
  logic [7:0]  overrun_cnt_reg;

  logic        strb;
  logic        trig;
  logic        load_snap;
  logic        ovr_evt;
  logic        accept;
  logic [15:0] ext_i, ext_u;
  logic [7:0]  frame_byte;

  // Narrow samples are zero-extended so the byte split is always 16-bit.
  always_comb begin
    ext_i              = '0;
    ext_u              = '0;
    ext_i[WIDTH-1:0]   = data_i;
    ext_u[WIDTH-1:0]   = data_u;
  end

  assign strb = s2_reg & ~s3_reg;
  assign trig = strb && (div_cnt_reg == DIV_LAST);

  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (strb) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_next = '0;
      end else begin
        div_cnt_next = div_cnt_reg + 16'd1;
      end
    end
  end

  assign accept = (state_reg == SEND) && tx.tx_ready;

  // Loads happen only from IDLE; a trigger while sending is dropped and counted.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_snap  = 1'b0;
    ovr_evt    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trig) begin
          load_snap  = 1'b1;
          state_next = SEND;
          idx_next   = 3'd0;
        end
      end
      SEND: begin
        ovr_evt = trig;
        if (accept) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
            idx_next   = 3'd0;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
      end
    endcase
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = snap_i_reg[15:8] ^ snap_i_reg[7:0] ^ snap_u_reg[15:8] ^ snap_u_reg[7:0];
`endif

  always_comb begin
    frame_byte = SYNC_BYTE;
    case (idx_reg)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = snap_i_reg[15:8];
      3'd2:    frame_byte = snap_i_reg[7:0];
      3'd3:    frame_byte = snap_u_reg[15:8];
      3'd4:    frame_byte = snap_u_reg[7:0];
`ifdef FRAME_CHECKSUM_EN
      3'd5:    frame_byte = csum;
`endif
      default: frame_byte = SYNC_BYTE;
    endcase
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign tx.tx_valid = (state_reg == SEND);
  assign tx.tx_data  = (state_reg == SEND) ? frame_byte : 8'h00;
  assign busy        = (state_reg != IDLE);
  assign overrun     = overrun_reg;
  assign overrun_cnt = overrun_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      s3_reg      <= 1'b0;
      div_cnt_reg <= '0;
    end else begin
      s1_reg      <= word_clk;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      div_cnt_reg <= div_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_i_reg <= '0;
      snap_u_reg <= '0;
    end else if (load_snap) begin
      snap_i_reg <= ext_i;
      snap_u_reg <= ext_u;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg     <= 1'b0;
      overrun_cnt_reg <= 8'h00;
    end else if (ovr_evt) begin
      overrun_reg <= 1'b1;
      if (overrun_cnt_reg != 8'hFF) begin
        overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed and randomized bench for uart_frame_sched against a byte-queue
// model of the frame stream, trigger schedule and overrun accounting.
module tb_uart_frame_sched;
  localparam int DIV = 4;

  logic        clk;
  logic        rst;
  logic        word_clk;
  logic [15:0] data_i;
  logic [15:0] data_u;
  logic        busy;
  logic        overrun;
  logic [7:0]  overrun_cnt;

  uart_frame_sched_if bus ();

  uart_frame_sched #(
    .WIDTH    (16),
    .FRAME_DIV(DIV),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word_clk   (word_clk),
    .data_i     (data_i),
    .data_u     (data_u),
    .tx         (bus.master),
    .busy       (busy),
    .overrun    (overrun),
    .overrun_cnt(overrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] q[$];
  int         trig_edges[$];
  int         pulse_n = 0;
  int         ecount = 0;
  bit         m_ovr = 0;
  int         m_cnt = 0;
  int         frames_done = 0;
  int         ready_mode = 1;
  logic [7:0] cur_frame[6];
  int         cur_pos = 0;
  logic [7:0] last_frame[6];
  int         last_len = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] di, input logic [15:0] du);
    q.push_back(8'hA5);
    q.push_back(di[15:8]);
    q.push_back(di[7:0]);
    q.push_back(du[15:8]);
    q.push_back(du[7:0]);
`ifdef FRAME_CHECKSUM_EN
    q.push_back(di[15:8] ^ di[7:0] ^ du[15:8] ^ du[7:0]);
`endif
  endtask

  // One clock cycle: drive ready, compare outputs, then advance the model.
  task automatic tick();
    bit busy_before;
    bit acc;
    case (ready_mode)
      0:       bus.tx_ready = 1'b0;
      1:       bus.tx_ready = 1'b1;
      2:       bus.tx_ready = ($urandom_range(0, 4) == 0);
      default: bus.tx_ready = ($urandom_range(0, 1) == 0);
    endcase
    busy_before = (q.size() != 0);
    chk("tx_valid", 16'(bus.tx_valid), 16'(busy_before));
    chk("busy", 16'(busy), 16'(busy_before));
    if (busy_before) chk("tx_data", 16'(bus.tx_data), 16'(q[0]));
    chk("overrun", 16'(overrun), 16'(m_ovr));
    chk("overrun_cnt", 16'(overrun_cnt), 16'(m_cnt));
    acc = busy_before && bus.tx_ready;
    if (acc && cur_pos < 6) cur_frame[cur_pos] = bus.tx_data;
    @(posedge clk);
    ecount++;
    if (acc) begin
      void'(q.pop_front());
      cur_pos++;
      if (q.size() == 0) begin
        frames_done++;
        last_frame = cur_frame;
        last_len   = cur_pos;
        cur_pos    = 0;
        $display("frame %0d: %h %h %h %h %h len=%0d", frames_done, cur_frame[0],
                 cur_frame[1], cur_frame[2], cur_frame[3], cur_frame[4], last_len);
      end
    end
    if (trig_edges.size() != 0 && trig_edges[0] == ecount) begin
      void'(trig_edges.pop_front());
      if (busy_before) begin
        m_ovr = 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        push_frame(data_i, data_u);
      end
    end
    @(negedge clk);
  endtask

  // word_clk rising at this negedge is seen as a trigger on the third edge.
  task automatic pulse(input int h, input int l);
    word_clk = 1'b1;
    pulse_n++;
    if (pulse_n % DIV == 0) trig_edges.push_back(ecount + 3);
    repeat (h) tick();
    word_clk = 1'b0;
    repeat (l) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx_valid", 16'(bus.tx_valid), 16'd0);
    chk("rst_tx_data", 16'(bus.tx_data), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_overrun_cnt", 16'(overrun_cnt), 16'd0);
    q.delete();
    trig_edges.delete();
    pulse_n = 0;
    m_ovr   = 0;
    m_cnt   = 0;
    cur_pos = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    ready_mode = 1;
    for (int g = 0; g < 400 && (q.size() != 0 || trig_edges.size() != 0); g++) tick();
    tick();
    chk("drained", 16'(bus.tx_valid), 16'd0);
  endtask

  initial begin
    int f0;
    rst          = 1'b0;
    word_clk     = 1'b0;
    data_i       = 16'h1234;
    data_u       = 16'hABCD;
    bus.tx_ready = 1'b1;
    #2;
    do_reset();

    // Two frames from eight strobes with the sink always ready.
    ready_mode = 1;
    f0 = frames_done;
    repeat (8) pulse(2, 2);
    drain();
    chk("t1_frames", 16'(frames_done - f0), 16'd2);
    chk("t1_b0", 16'(last_frame[0]), 16'h00A5);
    chk("t1_b1", 16'(last_frame[1]), 16'h0012);
    chk("t1_b2", 16'(last_frame[2]), 16'h0034);
    chk("t1_b3", 16'(last_frame[3]), 16'h00AB);
    chk("t1_b4", 16'(last_frame[4]), 16'h00CD);
    chk("t1_overrun", 16'(overrun), 16'd0);

    // Input change while a frame is in flight only affects the next frame.
    ready_mode = 2;
    repeat (4) pulse(2, 2);
    data_i = 16'hFFFF;
    drain();
    chk("t3_cur_hi", 16'(last_frame[1]), 16'h0012);
    chk("t3_cur_lo", 16'(last_frame[2]), 16'h0034);
    repeat (4) pulse(2, 2);
    drain();
    chk("t3_next_hi", 16'(last_frame[1]), 16'h00FF);
    chk("t3_next_lo", 16'(last_frame[2]), 16'h00FF);

    // Randomized data, strobe widths and backpressure.
    for (int n = 0; n < 160; n++) begin
      ready_mode = (n < 60) ? 2 : 3;
      data_i = 16'($urandom);
      data_u = 16'($urandom);
      pulse($urandom_range(1, 3), $urandom_range(1, 3));
    end
    drain();

    // Stalled sink: first frame stays pending, dropped triggers saturate.
    do_reset();
    data_i = 16'h1234;
    data_u = 16'hABCD;
    ready_mode = 0;
    repeat (1100) pulse(1, 1);
    chk("t4_overrun", 16'(overrun), 16'd1);
    chk("t4_cnt_sat", 16'(overrun_cnt), 16'h00FF);
    chk("t4_pending", 16'(bus.tx_data), 16'h00A5);
    chk("t4_valid", 16'(bus.tx_valid), 16'd1);

    // Reset in the middle of a frame, then a fresh decimation count.
    do_reset();
    ready_mode = 0;
    repeat (4) pulse(2, 2);
    ready_mode = 1;
    for (int g = 0; g < 20 && q.size() > 3; g++) tick();
    ready_mode = 0;
    tick();
    chk("t5_at_ilo", 16'(bus.tx_data), 16'h0034);
    do_reset();
    ready_mode = 1;
    repeat (3) pulse(2, 2);
    repeat (4) tick();
    chk("t5_no_early", 16'(bus.tx_valid), 16'd0);
    f0 = frames_done;
    pulse(2, 2);
    drain();
    chk("t5_frame", 16'(frames_done - f0), 16'd1);
    chk("t5_sync", 16'(last_frame[0]), 16'h00A5);
`ifdef FRAME_CHECKSUM_EN
    chk("t6_len", 16'(last_len), 16'd6);
    chk("t6_csum", 16'(last_frame[5]), 16'h0040);
`else
    chk("t6_len", 16'(last_len), 16'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
